// File: rtl/uart_tx_sequencer_if.sv
// Character handshake between the TX holding register/FIFO (master) and the
// transmit sequencer (slave).
interface uart_tx_sequencer_if;
  logic [7:0] DIN;
  logic       DIN_VALID;
  logic       DIN_READY;

  modport master (output DIN, output DIN_VALID, input DIN_READY);
  modport slave  (input DIN, input DIN_VALID, output DIN_READY);
endinterface

// File: rtl/uart_tx_sequencer.sv
// Serial-transmit sequencer for the APB UART: frames one character onto SOUT,
// timed by the oversampled baud enable.
//
// state    | meaning
// ---------+-----------------------------------------------------
// S_IDLE   | line idle high, DIN_READY=1, waiting for a character
// S_START  | start bit (low)
// S_DATA   | data bits, LSB first, from the shift register
// S_PARITY | parity bit computed at accept
// S_STOP   | stop period (1, 1.5 or 2 bit times), TXEND on last tick
module uart_tx_sequencer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CLEAR,
  input  logic                  BAUDCE,
  input  logic [1:0]            WLS,
  input  logic                  STB,
  input  logic                  PEN,
  input  logic                  EPS,
  input  logic                  SP,
  input  logic                  BC,
  uart_tx_sequencer_if.slave    din_if,
  output logic                  SOUT,
  output logic                  BUSY,
  output logic                  TXEND
);

  localparam int CW = $clog2(OVERSAMPLE + OVERSAMPLE);
  localparam logic [CW-1:0] BIT_LAST    = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] STOP15_LAST = CW'((3 * OVERSAMPLE) / 2 - 1);
  localparam logic [CW-1:0] STOP2_LAST  = CW'(2 * OVERSAMPLE - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state, state_d;
  logic [CW-1:0] tick, tick_d;
  logic [2:0]    bidx, bidx_d;
  logic [7:0]    shift, shift_d;
  logic [1:0]    wls_q, wls_d;
  logic          stb_q, stb_d;
  logic          pen_q, pen_d;
  logic          par_q, par_d;
  logic          fsm_sout, sout_d;
  logic          accept, bit_end;
  logic [CW-1:0] last_tick;
  logic [7:0]    dmask;

  assign din_if.DIN_READY = (state == S_IDLE);
  assign BUSY             = (state != S_IDLE);
  assign accept           = (state == S_IDLE) && din_if.DIN_VALID && !CLEAR;

  always_comb begin
    case (WLS)
      2'b00:   dmask = 8'h1F;
      2'b01:   dmask = 8'h3F;
      2'b10:   dmask = 8'h7F;
      default: dmask = 8'hFF;
    endcase
  end

  // Stop period length comes from the config latched at accept, not the live inputs.
  always_comb begin
    last_tick = BIT_LAST;
    if (state == S_STOP) begin
      if (!stb_q)              last_tick = BIT_LAST;
      else if (wls_q == 2'b00) last_tick = STOP15_LAST;
      else                     last_tick = STOP2_LAST;
    end
  end

  assign bit_end = BAUDCE && (tick == last_tick);

  always_comb begin
    state_d  = state;
    tick_d   = tick;
    bidx_d   = bidx;
    shift_d  = shift;
    wls_d    = wls_q;
    stb_d    = stb_q;
    pen_d    = pen_q;
    par_d    = par_q;
    TXEND    = 1'b0;
    fsm_sout = 1'b1;

    if (BAUDCE && (state != S_IDLE))
      tick_d = bit_end ? '0 : tick + CW'(1);

    case (state)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          tick_d  = '0;
          bidx_d  = '0;
          shift_d = din_if.DIN;
          wls_d   = WLS;
          stb_d   = STB;
          pen_d   = PEN;
          par_d   = SP ? ~EPS : (EPS ? ^(din_if.DIN & dmask) : ~^(din_if.DIN & dmask));
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift[7:1]};
          bidx_d  = bidx + 3'd1;
          // last index is word_len-1 = 4+WLS
          if (bidx == {1'b1, wls_q}) state_d = pen_q ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          TXEND   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (CLEAR) begin
      state_d = S_IDLE;
      tick_d  = '0;
      bidx_d  = '0;
      TXEND   = 1'b0;
    end

    // SOUT is registered, so it follows the state being entered.
    case (state_d)
      S_START:  fsm_sout = 1'b0;
      S_DATA:   fsm_sout = shift_d[0];
      S_PARITY: fsm_sout = par_q;
      default:  fsm_sout = 1'b1;
    endcase
    sout_d = BC ? 1'b0 : fsm_sout;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      tick  <= '0;
      bidx  <= '0;
      shift <= '0;
      wls_q <= '0;
      stb_q <= 1'b0;
      pen_q <= 1'b0;
      par_q <= 1'b0;
      SOUT  <= 1'b1;
    end else begin
      state <= state_d;
      tick  <= tick_d;
      bidx  <= bidx_d;
      shift <= shift_d;
      wls_q <= wls_d;
      stb_q <= stb_d;
      pen_q <= pen_d;
      par_q <= par_d;
      SOUT  <= sout_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: frame-level reference model compared every cycle,
// plus fixed-timing frames and abort scenarios with literal expectations.
module tb_uart_tx_sequencer;
  localparam int OS = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CLEAR = 1'b0;
  logic       BAUDCE = 1'b0;
  logic [1:0] WLS = 2'b11;
  logic       STB = 1'b0, PEN = 1'b0, EPS = 1'b0, SP = 1'b0, BC = 1'b0;
  logic       SOUT, BUSY, TXEND;

  uart_tx_sequencer_if dif ();

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bph = 0;
  bit baud_rand = 1'b0;
  int txend_cnt = 0;

  uart_tx_sequencer #(.OVERSAMPLE(OS)) dut (
    .CLK(CLK), .RST(RST), .CLEAR(CLEAR), .BAUDCE(BAUDCE),
    .WLS(WLS), .STB(STB), .PEN(PEN), .EPS(EPS), .SP(SP), .BC(BC),
    .din_if(dif), .SOUT(SOUT), .BUSY(BUSY), .TXEND(TXEND)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line levels of one frame, first bit in bit 0: start, data LSB first, parity, stop.
  function automatic logic [11:0] fbits(input logic [7:0] d, input logic [1:0] w,
                                        input logic pen, input logic eps, input logic sp);
    logic [11:0] b;
    int k, ones, wl;
    b = '0;
    wl = 5 + int'(w);
    ones = 0;
    k = 1;
    for (int i = 0; i < wl; i++) begin
      b[k] = d[i];
      ones += int'(d[i]);
      k++;
    end
    if (pen) begin
      b[k] = sp ? ~eps : (eps ? (ones % 2 == 1) : (ones % 2 == 0));
      k++;
    end
    b[k] = 1'b1;
    return b;
  endfunction

  function automatic int fnum(input logic [1:0] w, input logic pen);
    return 1 + 5 + int'(w) + (pen ? 1 : 0) + 1;
  endfunction

  function automatic int fstop(input logic [1:0] w, input logic stb);
    if (!stb) return OS;
    return (w == 2'b00) ? (3 * OS) / 2 : 2 * OS;
  endfunction

  // Reference model: compare outputs, then advance to what the coming edge produces.
  initial begin
    logic       m_busy, m_sout, e_txend;
    logic [11:0] m_bits;
    int         m_n, m_stop, m_seg, m_tick, seglen;
    m_busy = 1'b0; m_sout = 1'b1; m_bits = '0;
    m_n = 1; m_stop = OS; m_seg = 0; m_tick = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        m_busy = 1'b0; m_sout = 1'b1; m_seg = 0; m_tick = 0;
      end
      seglen  = (m_seg == m_n - 1) ? m_stop : OS;
      e_txend = m_busy && (m_seg == m_n - 1) && (m_tick == seglen - 1) && BAUDCE && !CLEAR && !RST;
      check("sout", SOUT, m_sout);
      check("busy", BUSY, m_busy);
      check("din_ready", dif.DIN_READY, !m_busy);
      check("txend", TXEND, e_txend);
      if (TXEND) txend_cnt++;
      if (!RST) begin
        if (CLEAR) begin
          m_busy = 1'b0; m_seg = 0; m_tick = 0;
        end else if (!m_busy) begin
          if (dif.DIN_VALID) begin
            m_bits = fbits(dif.DIN, WLS, PEN, EPS, SP);
            m_n    = fnum(WLS, PEN);
            m_stop = fstop(WLS, STB);
            m_busy = 1'b1; m_seg = 0; m_tick = 0;
          end
        end else if (BAUDCE) begin
          if (m_tick == seglen - 1) begin
            m_tick = 0;
            m_seg++;
            if (m_seg == m_n) m_busy = 1'b0;
          end else begin
            m_tick++;
          end
        end
        m_sout = BC ? 1'b0 : (m_busy ? m_bits[m_seg] : 1'b1);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    if (baud_rand) BAUDCE = ($urandom_range(0, 2) == 0);
    else begin
      bph = (bph + 1) % 4;
      BAUDCE = (bph == 0);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (BUSY && n < budget) begin
      step();
      n++;
    end
    check("frame_done_in_budget", BUSY, 1'b0);
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] w, input logic stb,
                      input logic pen, input logic eps, input logic sp);
    wait_idle(5000);
    WLS = w; STB = stb; PEN = pen; EPS = eps; SP = sp;
    dif.DIN = d;
    dif.DIN_VALID = 1'b1;
    step();
    dif.DIN_VALID = 1'b0;
  endtask

  // 8N1 frame with accept on a BAUDCE cycle so every bit lasts exactly 64 CLK.
  task automatic frame_aligned(input logic [7:0] d, input logic [9:0] lit,
                               input int bc_from, input int bc_to, input string tag);
    int t0;
    baud_rand = 1'b0;
    wait_idle(5000);
    WLS = 2'b11; PEN = 1'b0; STB = 1'b0; EPS = 1'b0; SP = 1'b0;
    dif.DIN = d;
    while (!BAUDCE) step();
    t0 = txend_cnt;
    dif.DIN_VALID = 1'b1;
    step();
    dif.DIN_VALID = 1'b0;
    for (int n = 0; n <= 640; n++) begin
      if (n == bc_from) BC = 1'b1;
      if (n == bc_to)   BC = 1'b0;
      #1;
      if (n % 64 == 32) begin
        if (n > bc_from && n <= bc_to) check({tag, "_sout_break"}, SOUT, 1'b0);
        else                           check({tag, "_sout_bit"}, SOUT, lit[n / 64]);
      end
      if (n == 0 || n == 320) check({tag, "_busy"}, BUSY, 1'b1);
      if (n == 639) check({tag, "_txend_at_639"}, TXEND, 1'b1);
      if (n == 640) check({tag, "_idle_at_640"}, BUSY, 1'b0);
      if (n < 640) step();
    end
    check({tag, "_txend_count"}, txend_cnt - t0, 1);
  endtask

  initial begin
    int t0, accepts, readyp, since2, n;
    logic [7:0] chars [3];
    logic [9:0] lit;
    dif.DIN = 8'h00;
    dif.DIN_VALID = 1'b0;

    // reset values
    step();
    check("rst_sout", SOUT, 1'b1);
    check("rst_busy", BUSY, 1'b0);
    check("rst_txend", TXEND, 1'b0);
    check("rst_ready", dif.DIN_READY, 1'b1);
    step(); step();
    RST = 1'b0;
    step();

    // model pins
    check("pin_8n1_55", fbits(8'h55, 2'b11, 1'b0, 1'b0, 1'b0), 12'h2AA);
    check("pin_8n1_len", fnum(2'b11, 1'b0), 10);
    check("pin_5e_e3", fbits(8'hE3, 2'b00, 1'b1, 1'b1, 1'b0), 12'h086);
    check("pin_stop_1p5", fstop(2'b00, 1'b1), 24);
    check("pin_stop_2", fstop(2'b10, 1'b1), 32);
    check("pin_stick_eps0", fbits(8'h00, 2'b11, 1'b1, 1'b0, 1'b1), 12'h600);
    check("pin_stick_eps1", fbits(8'h00, 2'b11, 1'b1, 1'b1, 1'b1), 12'h400);

    // 8N1 0x55 with exact timing
    lit = 10'h2AA;
    frame_aligned(8'h55, lit, -1, -1, "t1");

    // 5 bits, even parity, 1.5 stop; stick parity both ways
    baud_rand = 1'b1;
    send(8'hE3, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    send(8'h00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
    send(8'h00, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_idle(5000);

    // back-to-back with DIN_VALID held; WLS changed mid frame 2
    baud_rand = 1'b0;
    chars[0] = 8'hA5; chars[1] = 8'h3C; chars[2] = 8'h96;
    WLS = 2'b11; PEN = 1'b0; STB = 1'b0;
    t0 = txend_cnt; accepts = 0; readyp = 0; since2 = 0; n = 0;
    dif.DIN = chars[0];
    dif.DIN_VALID = 1'b1;
    while (accepts < 3 && n < 4000) begin
      logic acc_now;
      #1;
      if (dif.DIN_READY) readyp++;
      acc_now = dif.DIN_READY && dif.DIN_VALID;
      step();
      n++;
      if (acc_now) begin
        accepts++;
        if (accepts < 3) dif.DIN = chars[accepts];
        else dif.DIN_VALID = 1'b0;
      end
      if (accepts == 2) begin
        since2++;
        if (since2 == 100) WLS = 2'b00;
      end
    end
    check("b2b_accepts", accepts, 3);
    wait_idle(5000);
    check("b2b_ready_cycles", readyp, 3);
    check("b2b_txend_count", txend_cnt - t0, 3);

    // break during DATA of 0xFF
    lit = 10'h3FE;
    frame_aligned(8'hFF, lit, 150, 350, "t5");

    // CLEAR mid DATA
    baud_rand = 1'b0;
    send(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (200) step();
    t0 = txend_cnt;
    CLEAR = 1'b1;
    step();
    CLEAR = 1'b0;
    #1;
    check("clear_busy", BUSY, 1'b0);
    check("clear_sout", SOUT, 1'b1);
    repeat (700) step();
    check("clear_no_txend", txend_cnt - t0, 0);
    CLEAR = 1'b1;
    dif.DIN_VALID = 1'b1;
    step();
    CLEAR = 1'b0;
    dif.DIN_VALID = 1'b0;
    #1;
    check("clear_blocks_accept", BUSY, 1'b0);
    t0 = txend_cnt;
    send(8'hC3, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_idle(5000);
    check("after_clear_frame", txend_cnt - t0, 1);

    // RST mid DATA
    send(8'h81, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (200) step();
    RST = 1'b1;
    #1;
    check("rst_mid_busy", BUSY, 1'b0);
    check("rst_mid_sout", SOUT, 1'b1);
    repeat (3) step();
    RST = 1'b0;
    t0 = txend_cnt;
    repeat (700) step();
    check("rst_mid_no_txend", txend_cnt - t0, 0);
    send(8'h7E, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_idle(5000);
    check("after_rst_frame", txend_cnt - t0, 1);

    // randomized frames with mid-frame config changes, breaks and rare aborts
    baud_rand = 1'b1;
    for (int f = 0; f < 8; f++) begin
      send(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      n = 0;
      while (BUSY && n < 3000) begin
        step();
        n++;
        if ($urandom_range(0, 199) == 0) BC = ~BC;
        if ($urandom_range(0, 99) == 0) begin
          WLS = 2'($urandom); STB = 1'($urandom); PEN = 1'($urandom);
          EPS = 1'($urandom); SP = 1'($urandom);
        end
        if ($urandom_range(0, 1499) == 0) begin
          CLEAR = 1'b1;
          step();
          CLEAR = 1'b0;
        end
      end
      BC = 1'b0;
      check("rand_frame_done", BUSY, 1'b0);
    end
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
